// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the convolutional encoder and the Viterbi decoder:
// memory/state-count derivation, generator mask conversion and the encoder FSM states.
package viterbi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } enc_state_t;

    function automatic int calc_m(input int k);
        return k - 1;
    endfunction

    function automatic int calc_s(input int k);
        return 1 << (k - 1);
    endfunction

    // An octal literal already carries the tap bits; keep only the K window taps.
    function automatic logic [31:0] oct2mask(input int oct, input int k);
        logic [31:0] full;
        full = 32'(oct);
        return full & ((32'd1 << k) - 32'd1);
    endfunction

endpackage

// File: rtl/expected_bits.sv
// Symbol generation shared by encoder and decoder: parity of window {sr, b} against G0/G1.
module expected_bits #(
    parameter int           K  = 4,
    parameter logic [K-1:0] G0 = '1,
    parameter logic [K-1:0] G1 = '1
) (
    input  logic [K-2:0] sr,
    input  logic         b,
    output logic [1:0]   sym
);
    logic [K-1:0] w;

    assign w   = {sr, b};
    assign sym = {^(w & G0), ^(w & G1)};

endmodule

// File: rtl/conv_encoder_core.sv
// Rate-1/2 feedforward convolutional encoder with valid/ready framing and optional
// M-bit zero tail so every frame ends the trellis in state 0.
module conv_encoder_core
    import viterbi_pkg::*;
#(
    parameter int K       = 4,
    parameter int G0_OCT  = 'o17,
    parameter int G1_OCT  = 'o13,
    parameter bit TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit_valid,
    output logic       in_bit_ready,
    input  logic       in_bit,
    input  logic       in_bit_last,
    output logic       tx_sym_valid,
    input  logic       tx_sym_ready,
    output logic [1:0] tx_sym,
    output logic       tx_sym_tail,
    output logic       tx_sym_last,
    output logic       busy
);
    localparam int           M  = calc_m(K);
    localparam int           TW = (M > 1) ? $clog2(M) : 1;
    localparam logic [K-1:0] G0 = K'(oct2mask(G0_OCT, K));
    localparam logic [K-1:0] G1 = K'(oct2mask(G1_OCT, K));
    localparam logic [TW-1:0] TAIL_INIT = TW'(M - 1);

    enc_state_t    state, state_n;
    logic [M-1:0]  sr, sr_n;
    logic [TW-1:0] tail_cnt, tail_cnt_n;
    logic          valid_n, tail_n, last_n;
    logic [1:0]    sym_n, enc_sym;
    logic          slot_free, accept, advance, enc_b;
    logic [M:0]    win;

    assign slot_free    = !tx_sym_valid || tx_sym_ready;
    assign in_bit_ready = (state != ST_TAIL) && slot_free;
    assign accept       = in_bit_valid && in_bit_ready;
    assign advance      = accept || ((state == ST_TAIL) && slot_free);
    assign enc_b        = (state == ST_TAIL) ? 1'b0 : in_bit;
    assign win          = {sr, enc_b};
    assign busy         = (state != ST_IDLE) || tx_sym_valid;

    expected_bits #(.K(K), .G0(G0), .G1(G1)) u_exp (
        .sr  (sr),
        .b   (enc_b),
        .sym (enc_sym)
    );

    always_comb begin
        state_n    = state;
        sr_n       = sr;
        tail_cnt_n = tail_cnt;
        valid_n    = tx_sym_valid;
        sym_n      = tx_sym;
        tail_n     = tx_sym_tail;
        last_n     = tx_sym_last;
        if (slot_free)
            valid_n = 1'b0;
        if (advance) begin
            valid_n = 1'b1;
            sym_n   = enc_sym;
            sr_n    = win[M-1:0];
            tail_n  = 1'b0;
            last_n  = 1'b0;
            case (state)
                ST_IDLE, ST_DATA: begin
                    state_n = ST_DATA;
                    if (in_bit_last) begin
                        if (TAIL_EN) begin
                            state_n    = ST_TAIL;
                            tail_cnt_n = TAIL_INIT;
                        end else begin
                            state_n = ST_IDLE;
                            sr_n    = '0;
                            last_n  = 1'b1;
                        end
                    end
                end
                ST_TAIL: begin
                    tail_n = 1'b1;
                    if (tail_cnt == '0) begin
                        // zero tail has flushed sr by now; clearing just makes it explicit
                        last_n     = 1'b1;
                        state_n    = ST_IDLE;
                        sr_n       = '0;
                        tail_cnt_n = TAIL_INIT;
                    end else begin
                        tail_cnt_n = tail_cnt - 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            sr           <= '0;
            tail_cnt     <= TAIL_INIT;
            tx_sym_valid <= 1'b0;
            tx_sym       <= 2'b00;
            tx_sym_tail  <= 1'b0;
            tx_sym_last  <= 1'b0;
        end else begin
            state        <= state_n;
            sr           <= sr_n;
            tail_cnt     <= tail_cnt_n;
            tx_sym_valid <= valid_n;
            tx_sym       <= sym_n;
            tx_sym_tail  <= tail_n;
            tx_sym_last  <= last_n;
        end
    end

endmodule

// File: doc/conv_encoder_core.md
# conv_encoder_core

Rate-1/2 feedforward convolutional encoder: the transmit-side counterpart of the Viterbi decoder core. It consumes a framed bit stream under valid/ready, emits one 2-bit symbol per bit under valid/ready, and terminates each frame with M = K−1 zero tail bits so the trellis ends in state 0. Its generator polynomials, trellis-state layout and symbol bit order are identical to the decoder's, so `tx_sym` connects directly to the decoder `rx_sym` port and `tx_sym_last` can drive the decoder `force_state0` port.

## Interface
- `K`, 4: constraint length, ≥2; M = K−1.
- `G0_OCT`, 'o17: generator 0 (octal); MSB taps oldest bit.
- `G1_OCT`, 'o13: generator 1 (octal).
- `TAIL_EN`, 1: 1 = append M zero tail bits after `in_bit_last`; 0 = no tail, `in_bit_last` only resets the state after its own symbol.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_bit_valid` in 1: input bit offered.
- `in_bit_ready` out 1: input bit accepted when both valid and ready are high.
- `in_bit` in 1: data bit.
- `in_bit_last` in 1: qualifies the final data bit of a frame.
- `tx_sym_valid` out 1: output symbol valid.
- `tx_sym_ready` in 1: downstream accepts the symbol.
- `tx_sym` out 2: {G0 parity, G1 parity}.
- `tx_sym_tail` out 1: the current symbol comes from a tail bit.
- `tx_sym_last` out 1: the current symbol is the last one of the frame.
- `busy` out 1: high when `state != ST_IDLE` or `tx_sym_valid` is high.

## Operation
- Shift state `sr[M-1:0]` has its newest bit at the LSB. Encode window w = {sr, b}, K bits. `tx_sym[1] = ^(w & G0)` and `tx_sym[0] = ^(w & G1)`. Next state `sr = {sr[M-2:0], b}`. This is the decoder's trellis: predecessors of s are s>>1 and (s>>1)|MSB.
- FSM states:
  - `ST_IDLE`: `sr` = 0. An accepted bit goes to `ST_DATA`, or to `ST_TAIL` if `in_bit_last` is set (with `TAIL_EN`=1).
  - `ST_DATA`: each accepted bit encodes and shifts. An accepted last bit goes to `ST_TAIL` if `TAIL_EN`=1, otherwise to `ST_IDLE` with `sr` cleared.
  - `ST_TAIL`: the FSM internally injects b=0 each time the output slot is free, counting `tail_cnt` from M−1 to 0. The symbol for `tail_cnt`==0 sets `tx_sym_last`, and the FSM then goes to `ST_IDLE` with `sr` = 0, which is guaranteed by construction.
- Output is a single register stage. The slot is free when `!tx_sym_valid || tx_sym_ready`.
- `in_bit_ready = (state != ST_TAIL) && slot_free`. This path is combinational from `tx_sym_ready` and is allowed.
- On stall (`tx_sym_valid && !tx_sym_ready`), `tx_sym`, `tx_sym_tail` and `tx_sym_last` hold stable and `sr` does not advance.
- With `TAIL_EN`=0, `tx_sym_last` marks the symbol of the `in_bit_last` bit and `tx_sym_tail` is never set.
- `in_bit` and `in_bit_last` are ignored when the handshake does not complete.

## Timing
- Reset values: `tx_sym_valid`=0, `tx_sym`=0, `tx_sym_tail`=0, `tx_sym_last`=0, `busy`=0, FSM=`ST_IDLE`, `sr`=0, `tail_cnt`=M−1. `in_bit_ready`=1 while idle.
- Latency: a bit accepted at edge n produces its symbol valid after edge n. With `tx_sym_ready` held high, throughput is 1 symbol/cycle, including tail symbols and back-to-back frames.
- The first bit of the next frame is accepted in the same cycle the last tail symbol drains. There is no idle bubble.
- Reset mid-frame, including mid-tail, aborts the frame: outputs go to reset values immediately and no partial tail is emitted.
- A single-bit frame (`in_bit_last` on the first bit) is legal and produces 1 + M symbols.

## Structure
- Shared package `viterbi_pkg`:
  - M and S derivation;
  - octal-to-mask conversion;
  - the `enc_state_t` enum (`ST_IDLE`/`ST_DATA`/`ST_TAIL`).
- Instantiate the existing `expected_bits` sub-module with inputs (`sr`, b). The encoder and decoder then share a single symbol-generation definition. Add no new sub-modules.

## Test plan
- K=4, 17/13, `tx_sym_ready`=1, bits 1,0,1,1 with last on the 4th:
  - `tx_sym` = 11,11,01,11,01,01,11;
  - `tx_sym_tail` on symbols 5–7;
  - `tx_sym_last` on symbol 7 only;
  - `in_bit_ready`=0 for 3 cycles.
- Single-bit frame, bit 1 with last: symbols 11,11,10,11, then `busy`=0.
- Backpressure: drop `tx_sym_ready` for 3 cycles mid-frame. `tx_sym` and `tx_sym_valid` stay stable, `in_bit_ready`=0, and the sequence is unchanged versus the unstalled run.
- Back-to-back frames: frame A's last tail symbol and frame B's first bit are accepted in the same cycle. B encodes from `sr`=0 and there is no gap.
- Assert `rst` during `ST_TAIL` after 1 tail symbol: outputs clear asynchronously. The next frame 1,0,1,1 reproduces the first scenario exactly.
- Loopback into the decoder core with `tx_sym_last` driving `force_state0`: 64 random bits decode error-free after D-cycle latency.
